// File: rtl/dkong_uart_tx.sv
// Buffered 8N1 UART transmitter for the ser_out debug line.
// Bytes are queued through a ready/valid FIFO and sent LSB-first, CLKS_PER_BIT cycles per bit.
module dkong_uart_tx #(
    parameter int CLKS_PER_BIT    = 1,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     masterclk,
    input  logic                     rst,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     ser_out,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]            BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic                       push;
    logic                       pop;
    logic                       fifo_empty;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud;
    logic [CW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          ser_next;
    logic          baud_end;

    assign fifo_empty = (fifo_count == '0);
    assign tx_ready   = !rst && (fifo_count != FULL_COUNT);
    assign push       = tx_valid && tx_ready;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign baud_end   = (baud == BAUD_LAST);

    always_ff @(posedge masterclk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge masterclk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge masterclk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            ser_out <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            ser_out <= ser_next;
        end
    end

    // ser_out is registered, so each branch sets the level for the bit that starts on this edge.
    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        ser_next     = ser_out;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                ser_next  = 1'b1;
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                    ser_next   = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                    ser_next     = shift[0];
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        ser_next   = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        ser_next     = shift[1];
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                        ser_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                        ser_next   = 1'b1;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                ser_next   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_dkong_uart_tx.sv
// Scoreboard bench for dkong_uart_tx: accepted bytes are queued, a receiver model decodes ser_out.
// A second instance with CLKS_PER_BIT=1 covers the single-cycle bit timing.
module tb_dkong_uart_tx;

    localparam int CPB   = 4;
    localparam int LOG2  = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ser_out;
    logic       busy;
    logic [2:0] fifo_count;

    logic [7:0] tx_data1;
    logic       tx_valid1;
    logic       tx_ready1;
    logic       ser_out1;
    logic       busy1;
    logic [2:0] fifo_count1;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    dkong_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(LOG2)) dut (
        .masterclk (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ser_out   (ser_out),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    dkong_uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH_LOG2(LOG2)) dut1 (
        .masterclk (clk),
        .rst       (rst),
        .tx_data   (tx_data1),
        .tx_valid  (tx_valid1),
        .tx_ready  (tx_ready1),
        .ser_out   (ser_out1),
        .busy      (busy1),
        .fifo_count(fifo_count1)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Receiver model: finds the start bit, samples each bit mid-cell, checks the byte against the queue.
    task automatic monitor();
        int         t;
        bit         active;
        logic [7:0] rx;
        logic [7:0] e;
        active = 0;
        t      = 0;
        rx     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
            end else if (!active) begin
                if (ser_out === 1'b0) begin
                    active = 1;
                    t      = 0;
                end
            end else begin
                t++;
            end
            if (active && !rst) begin
                if (t == CPB / 2) begin
                    chk("rx_start_bit", ser_out, 1'b0);
                end else if (t >= CPB + CPB / 2 && t < 9 * CPB && (t - CPB / 2) % CPB == 0) begin
                    rx[(t - CPB / 2) / CPB - 1] = ser_out;
                end else if (t == 9 * CPB + CPB / 2) begin
                    chk("rx_stop_bit", ser_out, 1'b1);
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rx_unexpected_frame: got 0x%0h expected no frame at %0t", rx, $time);
                    end else begin
                        e = sb.pop_front();
                        if (rx !== e) begin
                            errors++;
                            $display("FAIL rx_byte: got 0x%0h expected 0x%0h at %0t", rx, e, $time);
                        end
                    end
                    active = 0;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push(input logic [7:0] b);
        int   n;
        logic acc;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) chk("push_ready_timeout", tx_ready, 1'b1);
        tx_valid = 1'b1;
        tx_data  = b;
        acc      = tx_ready;
        @(posedge clk);
        if (acc) sb.push_back(b);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, busy, 1'b0);
        chk({name, "_sb_empty"}, sb.size(), 0);
        chk({name, "_line_high"}, ser_out, 1'b1);
    endtask

    task automatic stimulus();
        logic [9:0] fr;
        logic [7:0] d;
        logic       acc;
        int         n;
        int         bad;
        int         peak;
        bit         saw_full;

        // Reset state
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_valid1 = 1'b0;
        tx_data1  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ser_out", ser_out, 1'b1);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ser_out", ser_out, 1'b1);
        chk("post_rst_tx_ready", tx_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_fifo_count", fifo_count, 0);

        // Single frame, exact waveform
        push(8'hA5);
        chk("t1_no_bypass", ser_out, 1'b1);
        chk("t1_busy_after_push", busy, 1'b1);
        chk("t1_count_after_push", fifo_count, 1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            chk("t1_wave", ser_out, fr[i / CPB]);
        end
        chk("t1_busy_in_stop", busy, 1'b1);
        @(negedge clk);
        chk("t1_busy_fall", busy, 1'b0);
        drain("t1");

        // Three back-to-back frames
        peak = 0;
        push(8'h00);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        push(8'hFF);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        push(8'h3C);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        chk("t2_total_cycles", n + 1, 120);
        chk("t2_count_peak", peak, 2);
        drain("t2");

        // Held valid with incrementing data
        d        = 8'h01;
        saw_full = 0;
        for (int i = 0; i < 240; i++) begin
            tx_valid = 1'b1;
            tx_data  = d;
            acc      = tx_ready;
            if (fifo_count == 3'(DEPTH)) begin
                saw_full = 1;
                chk("t3_ready_low_when_full", tx_ready, 1'b0);
            end
            @(posedge clk);
            if (acc) begin
                sb.push_back(d);
                d++;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("t3_reached_full", saw_full, 1'b1);
        drain("t3");

        // Reset during data bit 3 with two bytes queued
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("t4_queued", fifo_count, 2);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("t4_ser_out", ser_out, 1'b1);
        chk("t4_fifo_count", fifo_count, 0);
        chk("t4_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("t4_ready_after_rst", tx_ready, 1'b1);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (ser_out !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        chk("t4_no_frames_after_rst", bad, 0);

        // One clock per bit
        tx_valid1 = 1'b1;
        tx_data1  = 8'h81;
        chk("t5_ready", tx_ready1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tx_valid1 = 1'b0;
        chk("t5_no_bypass", ser_out1, 1'b1);
        fr = {1'b1, 8'h81, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_wave", ser_out1, fr[i]);
        end
        @(negedge clk);
        chk("t5_busy_fall", busy1, 1'b0);
        chk("t5_line_idle", ser_out1, 1'b1);
        chk("t5_count", fifo_count1, 0);

        // Fill, then push on every pop edge so the count stays put while pointers wrap
        for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
        chk("t6_full_count", fifo_count, DEPTH);
        chk("t6_full_ready_low", tx_ready, 1'b0);
        n = 0;
        while (fifo_count == 3'(DEPTH) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_after_pop_count", fifo_count, DEPTH - 1);
        chk("t6_ready_after_pop", tx_ready, 1'b1);
        bad = 0;
        for (int j = 0; j < 3 * DEPTH; j++) begin
            repeat (10 * CPB - 1) begin
                @(negedge clk);
                if (fifo_count !== 3'(DEPTH - 1)) bad++;
            end
            d        = 8'($urandom);
            tx_valid = 1'b1;
            tx_data  = d;
            acc      = tx_ready;
            if (!acc) bad++;
            @(posedge clk);
            if (acc) sb.push_back(d);
            @(negedge clk);
            tx_valid = 1'b0;
            if (fifo_count !== 3'(DEPTH - 1)) bad++;
        end
        chk("t6_count_stable", bad, 0);
        drain("t6");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            acc      = tx_valid && tx_ready;
            d        = tx_data;
            @(posedge clk);
            if (acc) sb.push_back(d);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        drain("t7");
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
